// File: rtl/coin_input_conditioner.sv
// Coin/accept input conditioner: 2-FF sync, debounce FSM and one-cycle press pulse per channel,
// with coin-priority arbitration. Optional press counter enabled by COIN_CONDITIONER_EVENT_CNT_EN.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_raw,
  input  logic       a_raw,
  output logic       m_pulse,
  output logic       a_pulse,
  output logic       m_level,
  output logic       a_level,
  output logic [7:0] coin_cnt
);

  typedef enum logic [1:0] {IDLE, ARM_HI, HIGH, ARM_LO} deb_state_t;

  typedef struct packed {
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
  } deb_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Next-state of one debounce channel; press is raised only on the qualified rising edge.
  function automatic deb_t deb_step(input deb_state_t st, input logic [CNT_W-1:0] cnt,
                                    input logic s2);
    deb_t n;
    n.state = st;
    n.cnt   = cnt;
    n.level = 1'b0;
    n.press = 1'b0;
    case (st)
      IDLE: begin
        if (s2) begin
          n.state = ARM_HI;
          n.cnt   = CNT_ONE;
        end
      end
      ARM_HI: begin
        if (!s2) begin
          n.state = IDLE;
          n.cnt   = '0;
        end else if (cnt == CNT_MAX) begin
          n.state = HIGH;
          n.cnt   = '0;
          n.press = 1'b1;
        end else begin
          n.cnt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          n.state = ARM_LO;
          n.cnt   = CNT_ONE;
        end
      end
      ARM_LO: begin
        if (s2) begin
          n.state = HIGH;
          n.cnt   = '0;
        end else if (cnt == CNT_MAX) begin
          n.state = IDLE;
          n.cnt   = '0;
        end else begin
          n.cnt = cnt + CNT_ONE;
        end
      end
      default: begin
        n.state = IDLE;
        n.cnt   = '0;
      end
    endcase
    n.level = (n.state == HIGH) || (n.state == ARM_LO);
    return n;
  endfunction

  logic             r_m_s1, r_m_s2, r_a_s1, r_a_s2;
  deb_state_t       r_m_state, r_a_state;
  logic [CNT_W-1:0] r_m_cnt, r_a_cnt;
  logic             r_m_level, r_a_level;
  logic             r_m_pulse, r_a_pulse, r_a_pending;
  deb_t             w_m_nxt, w_a_nxt;
  logic             w_a_req;

  always_comb begin
    w_m_nxt = deb_step(r_m_state, r_m_cnt, r_m_s2);
    w_a_nxt = deb_step(r_a_state, r_a_cnt, r_a_s2);
  end

  // An accept press waits one cycle behind a same-cycle coin press; repeats while waiting merge.
  assign w_a_req = w_a_nxt.press | r_a_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_s1      <= 1'b0;
      r_m_s2      <= 1'b0;
      r_a_s1      <= 1'b0;
      r_a_s2      <= 1'b0;
      r_m_state   <= IDLE;
      r_a_state   <= IDLE;
      r_m_cnt     <= '0;
      r_a_cnt     <= '0;
      r_m_level   <= 1'b0;
      r_a_level   <= 1'b0;
      r_m_pulse   <= 1'b0;
      r_a_pulse   <= 1'b0;
      r_a_pending <= 1'b0;
    end else begin
      r_m_s1      <= m_raw;
      r_m_s2      <= r_m_s1;
      r_a_s1      <= a_raw;
      r_a_s2      <= r_a_s1;
      r_m_state   <= w_m_nxt.state;
      r_a_state   <= w_a_nxt.state;
      r_m_cnt     <= w_m_nxt.cnt;
      r_a_cnt     <= w_a_nxt.cnt;
      r_m_level   <= w_m_nxt.level;
      r_a_level   <= w_a_nxt.level;
      r_m_pulse   <= w_m_nxt.press;
      r_a_pulse   <= w_a_req & ~w_m_nxt.press;
      r_a_pending <= w_a_req & w_m_nxt.press;
    end
  end

  assign m_pulse = r_m_pulse;
  assign a_pulse = r_a_pulse;
  assign m_level = r_m_level;
  assign a_level = r_a_level;

`ifdef COIN_CONDITIONER_EVENT_CNT_EN
  logic [7:0] r_coin_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coin_cnt <= 8'h00;
    end else if (w_m_nxt.press && (r_coin_cnt != 8'hFF)) begin
      r_coin_cnt <= r_coin_cnt + 8'd1;
    end
  end

  assign coin_cnt = r_coin_cnt;
`else
  assign coin_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: behavioural model compared every cycle plus directed latency checks.
module tb_coin_input_conditioner;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_raw, a_raw;
  logic       m_pulse, a_pulse, m_level, a_level;
  logic [7:0] coin_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .m_raw(m_raw), .a_raw(a_raw),
    .m_pulse(m_pulse), .a_pulse(a_pulse), .m_level(m_level), .a_level(a_level),
    .coin_cnt(coin_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: a level flips once the last DEB+1 synchronized samples all show the opposite value.
  bit         model_ok = 1'b0;
  bit         ms1, ms2, as1, as2, mlv, alv, pend, em, ea;
  bit [DEB:0] mh, ah;
  int         mn, an, ecnt;

  always @(posedge clk) begin
    bit mi, ai, mp, ap;
    cyc++;
    if (reset) begin
      model_ok = 1'b1;
      {ms1, ms2, as1, as2, mlv, alv, pend, em, ea} = '0;
      mh = '0; ah = '0; mn = 0; an = 0; ecnt = 0;
    end else begin
      mi = ms2; ms2 = ms1; ms1 = m_raw;
      ai = as2; as2 = as1; as1 = a_raw;
      mh = {mh[DEB-1:0], mi}; if (mn < DEB + 1) mn++;
      ah = {ah[DEB-1:0], ai}; if (an < DEB + 1) an++;
      mp = 1'b0; ap = 1'b0;
      if (mn == DEB + 1 && !mlv && mh == '1) begin mlv = 1'b1; mp = 1'b1; end
      else if (mn == DEB + 1 && mlv && mh == '0) mlv = 1'b0;
      if (an == DEB + 1 && !alv && ah == '1) begin alv = 1'b1; ap = 1'b1; end
      else if (an == DEB + 1 && alv && ah == '0) alv = 1'b0;
      em   = mp;
      ea   = !mp && (ap || pend);
      pend = mp && (ap || pend);
      if (mp && ecnt < 255) ecnt++;
    end
  end

  always @(posedge clk) begin
    int exp_cnt;
    #1;
    if (model_ok) begin
`ifdef COIN_CONDITIONER_EVENT_CNT_EN
      exp_cnt = ecnt;
`else
      exp_cnt = 0;
`endif
      chk("m_pulse", int'(m_pulse), int'(em));
      chk("a_pulse", int'(a_pulse), int'(ea));
      chk("m_level", int'(m_level), int'(mlv));
      chk("a_level", int'(a_level), int'(alv));
      chk("coin_cnt", int'(coin_cnt), exp_cnt);
      chk("pulse_exclusive", int'(m_pulse && a_pulse), 0);
    end
  end

  // which: 0 m_pulse high, 1 a_pulse high, 2 m_level low
  task automatic wait_for(input int which, input int limit, output int at);
    bit hit;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      case (which)
        0:       hit = m_pulse;
        1:       hit = a_pulse;
        default: hit = !m_level;
      endcase
      if (hit) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cycle %0d: got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, at, bp, rel;
    reset = 1'b1; m_raw = 1'b0; a_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_m_level", int'(m_level), 0);
    chk("reset_a_level", int'(a_level), 0);
    chk("reset_m_pulse", int'(m_pulse), 0);
    chk("reset_coin_cnt", int'(coin_cnt), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Clean press, then release
    m_raw = 1'b1; n = cyc + 1;
    wait_for(0, 40, at);
    chk("clean_latency", at - n, DEB + 2);
    chk("clean_level", int'(m_level), 1);
    @(posedge clk); #1;
    chk("clean_width", int'(m_pulse), 0);
    repeat (20) @(negedge clk);
    m_raw = 1'b0; n = cyc + 1;
    wait_for(2, 40, at);
    chk("release_latency", at - n, DEB + 2);
    repeat (6) @(negedge clk);

    // Bounce then steady
    bp = 0;
    for (int seg = 0; seg < 10; seg++) begin
      @(negedge clk);
      m_raw = (seg % 2 == 0);
      repeat (3) begin
        @(posedge clk); #1;
        if (m_pulse) bp++;
      end
    end
    chk("bounce_no_pulse", bp, 0);
    @(negedge clk);
    m_raw = 1'b1; n = cyc + 1;
    wait_for(0, 40, at);
    chk("bounce_latency", at - n, DEB + 2);
    @(negedge clk); m_raw = 1'b0;
    repeat (14) @(negedge clk);

    // Simultaneous presses: coin first, accept one cycle later
    m_raw = 1'b1; a_raw = 1'b1; n = cyc + 1;
    wait_for(0, 40, at);
    chk("simul_m_latency", at - n, DEB + 2);
    chk("simul_a_held", int'(a_pulse), 0);
    @(posedge clk); #1;
    chk("simul_a_next", int'(a_pulse), 1);
    chk("simul_m_done", int'(m_pulse), 0);
    @(negedge clk); m_raw = 1'b0; a_raw = 1'b0;
    repeat (14) @(negedge clk);

    // Reset while accept is mid-debounce (count 5)
    a_raw = 1'b1; n = cyc + 1;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_a_level", int'(a_level), 0);
    chk("rst_mid_a_pulse", int'(a_pulse), 0);
    reset = 1'b0; rel = cyc + 1;
    wait_for(1, 40, at);
    chk("rst_requal_latency", at - rel, DEB + 2);
    chk("rst_requal_level", int'(a_level), 1);
    @(negedge clk); a_raw = 1'b0;
    repeat (14) @(negedge clk);

    // 300 clean coin presses
    for (int k = 0; k < 300; k++) begin
      m_raw = 1'b1;
      repeat (12) @(negedge clk);
      m_raw = 1'b0;
      repeat (12) @(negedge clk);
    end
`ifdef COIN_CONDITIONER_EVENT_CNT_EN
    chk("coin_cnt_saturate", int'(coin_cnt), 255);
`else
    chk("coin_cnt_tied", int'(coin_cnt), 0);
`endif
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
